// File: rtl/uio_bus_arbiter.sv
// uio_bus_arbiter: round-robin owner of the shared uio pad bus.
// Each grant is preceded by an undriven turnaround window and limited to
// HOLD_MAX beats, so two engines never drive the pads in the same cycle.
module uio_bus_arbiter #(
  parameter int N_REQ    = 3,
  parameter int DATA_W   = 8,
  parameter int HOLD_MAX = 4,
  parameter int TURN_CYC = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ena,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ-1:0]          dir,
  input  logic [N_REQ*DATA_W-1:0]   wdata,
  input  logic [N_REQ-1:0]          last,
  input  logic [DATA_W-1:0]         uio_in,
  output logic [N_REQ-1:0]          gnt,
  output logic                      ack,
  output logic [DATA_W-1:0]         rdata,
  output logic                      rvalid,
  output logic [DATA_W-1:0]         uio_out,
  output logic [DATA_W-1:0]         uio_oe,
  output logic                      busy
);

  localparam int PTR_W = $clog2(N_REQ);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_TURN = 2'd1,
    S_XFER = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [PTR_W-1:0]     owner_q, owner_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic                 dir_q, dir_d;
  logic [1:0]           turn_q, turn_d;
  logic [3:0]           beat_q, beat_d;
  logic [N_REQ-1:0]     gnt_q, gnt_d;
  logic [DATA_W-1:0]    rdata_q, rdata_d;
  logic                 rvalid_q, rvalid_d;

  logic                 win_found;
  logic [PTR_W-1:0]     win_idx;
  int                   scan_idx;
  logic                 xfer_wr;

  // Round-robin scan: first set request after the previous owner, with wrap.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      scan_idx = (int'(ptr_q) + k) % N_REQ;
      if (!win_found && req[PTR_W'(scan_idx)]) begin
        win_found = 1'b1;
        win_idx   = PTR_W'(scan_idx);
      end
    end
  end

  // A beat is accepted only while the owner holds the bus and the design is enabled.
  assign ack = (state_q == S_XFER) && ena && req[owner_q];

  // Next-state, grant, beat counting and read-data capture.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    dir_d    = dir_q;
    turn_d   = turn_q;
    beat_d   = beat_q;
    gnt_d    = gnt_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;

    if (ack && !dir_q) begin
      rdata_d  = uio_in;
      rvalid_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        gnt_d  = '0;
        beat_d = '0;
        if (ena && win_found) begin
          owner_d = win_idx;
          dir_d   = dir[win_idx];
          ptr_d   = win_idx;
          turn_d  = '0;
          state_d = S_TURN;
        end
      end
      S_TURN: begin
        if (!ena || !req[owner_q]) begin
          state_d = S_IDLE;
        end else if (turn_q == 2'(TURN_CYC - 1)) begin
          state_d = S_XFER;
          gnt_d   = {{(N_REQ-1){1'b0}}, 1'b1} << owner_q;
          beat_d  = '0;
        end else begin
          turn_d = turn_q + 2'd1;
        end
      end
      S_XFER: begin
        if (!ack) begin
          state_d = S_IDLE;
          gnt_d   = '0;
          beat_d  = '0;
        end else if (last[owner_q] || (beat_q + 4'd1 == 4'(HOLD_MAX))) begin
          state_d = S_IDLE;
          gnt_d   = '0;
          beat_d  = '0;
        end else begin
          beat_d = beat_q + 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
        beat_d  = '0;
      end
    endcase
  end

  // State register; reset aborts any burst and leaves req[0] first in line.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      owner_q  <= '0;
      ptr_q    <= PTR_W'(N_REQ - 1);
      dir_q    <= 1'b0;
      turn_q   <= '0;
      beat_q   <= '0;
      gnt_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      dir_q    <= dir_d;
      turn_q   <= turn_d;
      beat_q   <= beat_d;
      gnt_q    <= gnt_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  // Pads are driven only by a write owner in XFER; all-ones or all-zeros enable.
  assign xfer_wr = (state_q == S_XFER) && dir_q;
  assign uio_oe  = {DATA_W{xfer_wr}};
  assign uio_out = xfer_wr ? wdata[owner_q*DATA_W +: DATA_W] : '0;
  assign gnt     = gnt_q;
  assign rdata   = rdata_q;
  assign rvalid  = rvalid_q;
  assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Bench for uio_bus_arbiter: directed scenarios plus random traffic, all
// compared cycle by cycle against a transaction-level ownership model.
module tb_uio_bus_arbiter;

  localparam int N  = 3;
  localparam int W  = 8;
  localparam int HM = 4;
  localparam int TC = 1;
  localparam int VW = N + 1 + W + 1 + W + W + 1;

  logic           clk = 1'b0;
  logic           rst, ena;
  logic [N-1:0]   req, dir, last;
  logic [N*W-1:0] wdata;
  logic [W-1:0]   uio_in;
  logic [N-1:0]   gnt;
  logic           ack, rvalid, busy;
  logic [W-1:0]   rdata, uio_out, uio_oe;
  logic [VW-1:0]  act_vec;
  logic [N-1:0]   mon_prev = '0;

  int total = 0;
  int bad   = 0;

  // Model: owner index (-1 = nobody), remaining turnaround cycles, beats taken.
  int         m_owner = -1;
  int         m_turn_left = 0;
  int         m_beats = 0;
  int         m_ptr = N - 1;
  bit         m_dir = 1'b0;
  logic [W-1:0] m_rdata = '0;
  bit         m_rvalid = 1'b0;

  uio_bus_arbiter #(.N_REQ(N), .DATA_W(W), .HOLD_MAX(HM), .TURN_CYC(TC)) dut (
    .clk(clk), .rst(rst), .ena(ena), .req(req), .dir(dir), .wdata(wdata),
    .last(last), .uio_in(uio_in), .gnt(gnt), .ack(ack), .rdata(rdata),
    .rvalid(rvalid), .uio_out(uio_out), .uio_oe(uio_oe), .busy(busy)
  );

  always #5 clk = ~clk;

  assign act_vec = {gnt, ack, rdata, rvalid, uio_out, uio_oe, busy};

  always @(negedge clk) begin
    if (gnt != '0 && mon_prev == '0)
      $display("grant gnt=%b oe=%h out=%h t=%0t", gnt, uio_oe, uio_out, $time);
    mon_prev <= gnt;
  end

  function automatic logic [VW-1:0] exp_vec();
    logic [N-1:0] g;
    logic a, bz;
    logic [W-1:0] o, oe;
    g = '0; a = 1'b0; o = '0; oe = '0;
    bz = (m_owner >= 0);
    if (m_owner >= 0 && m_turn_left == 0) begin
      g[m_owner] = 1'b1;
      a = ena && req[m_owner];
      if (m_dir) begin
        oe = '1;
        o  = wdata[m_owner*W +: W];
      end
    end
    return {g, a, m_rdata, m_rvalid, o, oe, bz};
  endfunction

  task automatic model_step();
    bit a;
    int w;
    if (rst) begin
      m_owner = -1; m_turn_left = 0; m_beats = 0; m_ptr = N - 1;
      m_rdata = '0; m_rvalid = 1'b0;
      return;
    end
    a = 1'b0;
    if (m_owner >= 0 && m_turn_left == 0) a = ena && req[m_owner];
    m_rvalid = a && !m_dir;
    if (a && !m_dir) m_rdata = uio_in;
    if (m_owner < 0) begin
      if (ena && req != '0) begin
        w = -1;
        for (int k = 1; k <= N; k++)
          if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
        m_owner = w; m_dir = dir[w]; m_ptr = w;
        m_turn_left = TC; m_beats = 0;
      end
    end else if (m_turn_left > 0) begin
      if (!ena || !req[m_owner]) m_owner = -1;
      else m_turn_left--;
    end else begin
      if (!a) begin
        m_owner = -1; m_beats = 0;
      end else begin
        m_beats++;
        if (last[m_owner] || m_beats == HM) begin
          m_owner = -1; m_beats = 0;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      rst = 1'b1; ena = 1'b1; req = N'($urandom); dir = N'($urandom);
      last = N'($urandom); wdata = (N*W)'({$urandom, $urandom}); uio_in = W'($urandom);
      @(negedge clk);
      total++;
      if (act_vec !== '0) begin
        bad++; $display("FAIL reset_vals cyc=%0d got=%h want=0", c, act_vec);
      end
      total++;
      if (act_vec !== exp_vec()) begin
        bad++; $display("FAIL reset_model cyc=%0d got=%h want=%h", c, act_vec, exp_vec());
      end
      tick();
    end
    rst = 1'b0; req = '0; last = '0;
  endtask

  task automatic test_write();
    for (int c = 0; c < 5; c++) begin
      req = (c < 4) ? 3'b001 : 3'b000; dir = 3'b001; ena = 1'b1;
      wdata = {8'h11, 8'h22, 8'hA5}; last = (c == 3) ? 3'b001 : 3'b000;
      uio_in = W'($urandom);
      @(negedge clk);
      total++;
      if (act_vec !== exp_vec()) begin
        bad++; $display("FAIL write_model cyc=%0d got=%h want=%h", c, act_vec, exp_vec());
      end
      if (c == 2 || c == 3) begin
        total++;
        if ({gnt, ack, uio_oe, uio_out} !== {3'b001, 1'b1, 8'hFF, 8'hA5}) begin
          bad++; $display("FAIL write_beat cyc=%0d got=%b/%b/%h/%h want=001/1/ff/a5", c, gnt, ack, uio_oe, uio_out);
        end
      end
      if (c == 4) begin
        total++;
        if ({gnt, uio_oe, busy} !== {3'b000, 8'h00, 1'b0}) begin
          bad++; $display("FAIL write_end got=%b/%h/%b want=000/00/0", gnt, uio_oe, busy);
        end
      end
      tick();
    end
  endtask

  task automatic test_rotation();
    logic [N-1:0] order [$];
    int acks [$];
    int zero_run, min_gap;
    logic [N-1:0] drv_gnt, prev_gnt;
    logic [N-1:0] exp_order [4];
    exp_order = '{3'b001, 3'b010, 3'b100, 3'b001};
    zero_run = 0; min_gap = 99; drv_gnt = '0; prev_gnt = '0;
    rst = 1'b1; req = '0; @(negedge clk); tick(); rst = 1'b0;
    for (int c = 0; c < 24; c++) begin
      req = 3'b111; dir = 3'b111; last = '0; ena = 1'b1;
      wdata = (N*W)'({$urandom, $urandom}); uio_in = W'($urandom);
      @(negedge clk);
      total++;
      if (act_vec !== exp_vec()) begin
        bad++; $display("FAIL rot_model cyc=%0d got=%h want=%h", c, act_vec, exp_vec());
      end
      if (gnt != '0 && prev_gnt == '0) begin order.push_back(gnt); acks.push_back(0); end
      if (ack && acks.size() > 0) acks[acks.size()-1]++;
      if (uio_oe == '0) zero_run++;
      else begin
        if (drv_gnt != '0 && gnt != drv_gnt && zero_run < min_gap) min_gap = zero_run;
        zero_run = 0; drv_gnt = gnt;
      end
      prev_gnt = gnt;
      tick();
    end
    req = '0;
    total++;
    if (order.size() != 4) begin
      bad++; $display("FAIL rot_count got=%0d want=4", order.size());
    end
    for (int i = 0; i < 4 && i < order.size(); i++) begin
      total++;
      if (order[i] !== exp_order[i] || acks[i] != HM) begin
        bad++; $display("FAIL rot_grant idx=%0d got=%b/%0d want=%b/%0d", i, order[i], acks[i], exp_order[i], HM);
      end
    end
    total++;
    if (min_gap < TC + 1) begin
      bad++; $display("FAIL rot_gap got=%0d want>=%0d", min_gap, TC + 1);
    end
  endtask

  task automatic test_read();
    for (int c = 0; c < 6; c++) begin
      req = (c < 4) ? 3'b010 : 3'b000; dir = 3'b000; ena = 1'b1;
      last = (c == 3) ? 3'b010 : 3'b000;
      uio_in = (c == 2) ? 8'h3C : (c == 3) ? 8'hC3 : W'($urandom);
      @(negedge clk);
      total++;
      if (act_vec !== exp_vec()) begin
        bad++; $display("FAIL read_model cyc=%0d got=%h want=%h", c, act_vec, exp_vec());
      end
      total++;
      if (uio_oe !== 8'h00) begin
        bad++; $display("FAIL read_oe cyc=%0d got=%h want=00", c, uio_oe);
      end
      if (c == 3 || c == 4) begin
        total++;
        if ({rvalid, rdata} !== {1'b1, (c == 3) ? 8'h3C : 8'hC3}) begin
          bad++; $display("FAIL read_data cyc=%0d got=%b/%h want=1/%h", c, rvalid, rdata, (c == 3) ? 8'h3C : 8'hC3);
        end
      end
      if (c == 5) begin
        total++;
        if (rvalid !== 1'b0) begin
          bad++; $display("FAIL read_rvalid_drop got=%b want=0", rvalid);
        end
      end
      tick();
    end
  endtask

  task automatic test_ena_drop();
    for (int c = 0; c < 8; c++) begin
      req = 3'b001; dir = 3'b001; last = '0;
      ena = (c == 3 || c == 4) ? 1'b0 : 1'b1;
      wdata = (N*W)'({$urandom, $urandom}); uio_in = W'($urandom);
      @(negedge clk);
      total++;
      if (act_vec !== exp_vec()) begin
        bad++; $display("FAIL ena_model cyc=%0d got=%h want=%h", c, act_vec, exp_vec());
      end
      if (c == 3) begin
        total++;
        if (ack !== 1'b0) begin
          bad++; $display("FAIL ena_no_ack got=%b want=0", ack);
        end
      end
      if (c == 4) begin
        total++;
        if ({gnt, uio_oe, ack} !== {3'b000, 8'h00, 1'b0}) begin
          bad++; $display("FAIL ena_idle got=%b/%h/%b want=000/00/0", gnt, uio_oe, ack);
        end
      end
      if (c == 6) begin
        total++;
        if ({gnt, busy} !== {3'b000, 1'b1}) begin
          bad++; $display("FAIL ena_turn got=%b/%b want=000/1", gnt, busy);
        end
      end
      if (c == 7) begin
        total++;
        if (gnt !== 3'b001) begin
          bad++; $display("FAIL ena_regrant got=%b want=001", gnt);
        end
      end
      tick();
    end
    req = '0;
  endtask

  task automatic test_reset_mid();
    bit found;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      req = 3'b101; dir = 3'b101; last = '0; ena = 1'b1;
      wdata = (N*W)'({$urandom, $urandom}); uio_in = W'($urandom);
      @(negedge clk);
      total++;
      if (act_vec !== exp_vec()) begin
        bad++; $display("FAIL rstmid_model cyc=%0d got=%h want=%h", c, act_vec, exp_vec());
      end
      if (uio_oe === 8'hFF) found = 1'b1;
      tick();
    end
    total++;
    if (!found) begin
      bad++; $display("FAIL rstmid_timeout got=no_write want=write_burst");
    end
    rst = 1'b1; @(negedge clk); tick(); rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if (act_vec !== exp_vec()) begin
        bad++; $display("FAIL rstmid_after cyc=%0d got=%h want=%h", c, act_vec, exp_vec());
      end
      if (c == 0) begin
        total++;
        if (act_vec !== '0) begin
          bad++; $display("FAIL rstmid_zero got=%h want=0", act_vec);
        end
      end
      if (c == 2) begin
        total++;
        if (gnt !== 3'b001) begin
          bad++; $display("FAIL rstmid_first got=%b want=001", gnt);
        end
      end
      tick();
    end
    req = '0;
  endtask

  task automatic test_turn_drop();
    rst = 1'b1; req = '0; @(negedge clk); tick(); rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      req = (c == 0) ? 3'b101 : 3'b100; dir = 3'b101; last = '0; ena = 1'b1;
      wdata = (N*W)'({$urandom, $urandom}); uio_in = W'($urandom);
      @(negedge clk);
      total++;
      if (act_vec !== exp_vec()) begin
        bad++; $display("FAIL tdrop_model cyc=%0d got=%h want=%h", c, act_vec, exp_vec());
      end
      if (c < 4) begin
        total++;
        if ({gnt, ack} !== 4'b0000) begin
          bad++; $display("FAIL tdrop_nogrant cyc=%0d got=%b/%b want=000/0", c, gnt, ack);
        end
      end
      if (c == 2) begin
        total++;
        if (busy !== 1'b0) begin
          bad++; $display("FAIL tdrop_idle got=%b want=0", busy);
        end
      end
      if (c == 4) begin
        total++;
        if (gnt !== 3'b100) begin
          bad++; $display("FAIL tdrop_pending got=%b want=100", gnt);
        end
      end
      tick();
    end
    req = '0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      rst = ($urandom_range(0, 127) == 0);
      ena = ($urandom_range(0, 15) != 0);
      for (int i = 0; i < N; i++) begin
        if (!req[i]) req[i] = ($urandom_range(0, 3) == 0);
        else if ($urandom_range(0, 15) == 0) req[i] = 1'b0;
        last[i] = ($urandom_range(0, 3) == 0);
      end
      dir = N'($urandom); wdata = (N*W)'({$urandom, $urandom}); uio_in = W'($urandom);
      @(negedge clk);
      total++;
      if (act_vec !== exp_vec()) begin
        bad++; $display("FAIL rand_model cyc=%0d got=%h want=%h", c, act_vec, exp_vec());
      end
      tick();
    end
    rst = 1'b0; req = '0;
  endtask

  initial begin
    rst = 1'b1; ena = 1'b0; req = '0; dir = '0; last = '0; wdata = '0; uio_in = '0;
    tick();
    test_reset();
    test_write();
    test_rotation();
    test_read();
    test_ena_drop();
    test_reset_mid();
    test_turn_drop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uio_bus_arbiter.md
Name: uio_bus_arbiter

Overview:
- Shares the 8-bit bidirectional uio pad bus (uio_in/uio_out/uio_oe) of tt_um_BH2VGM_DG0045 between N_REQ internal puzzle engines, e.g. the puzzle FSM, score logger and debug port.
- Round-robin grant with a bounded burst length per grant.
- Forced bus-turnaround gap between owners, so two drivers never overlap and pad direction never flips within a cycle.
- Sits between the internal requesters and the top-level uio pins.

Parameters:
- N_REQ, 3, number of requesters (2..8).
- DATA_W, 8, bus width; must equal uio width.
- HOLD_MAX, 4, max beats per grant before forced release (1..15).
- TURN_CYC, 1, undriven cycles inserted before every grant (1..3).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset. Top level drives it as ~rst_n.
- ena  in  1  design enable; low forces idle.
- req  in  N_REQ  per-requester bus request; level, held until done.
- dir  in  N_REQ  per-requester direction; 1 = drive pins (write), 0 = sample pins (read). Sampled at grant.
- wdata  in  N_REQ*DATA_W  per-requester write data; slice i = bits [i*DATA_W +: DATA_W].
- last  in  N_REQ  marks the final beat of the owner's burst.
- uio_in  in  DATA_W  pad input.
- gnt  out  N_REQ  one-hot grant; registered.
- ack  out  1  beat accepted this cycle.
- rdata  out  DATA_W  registered read data.
- rvalid  out  1  rdata valid, one cycle.
- uio_out  out  DATA_W  pad output data.
- uio_oe  out  DATA_W  pad output enable; all-ones or all-zeros only.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (rst=1 at a clk edge) values:
  - state=IDLE; gnt=0, ack=0, rvalid=0.
  - rdata=0, uio_out=0, uio_oe=0, busy=0.
  - rr pointer = N_REQ-1, so req[0] has first priority. Beat counter = 0.
  - Reset mid-burst aborts immediately. No pin is left driven after the reset cycle.
- FSM has three states: IDLE, TURN, XFER.
- IDLE:
  - If ena=1 and req!=0, the winner is the first set req scanning from (ptr+1) mod N_REQ upward with wrap.
  - Latch owner, owner_dir=dir[owner]; ptr<=owner; turn counter=0; go TURN.
- TURN:
  - uio_oe=0, gnt=0. Counts TURN_CYC cycles, then goes XFER with gnt<=onehot(owner).
  - If req[owner] drops during TURN, return to IDLE with no beat.
- XFER:
  - ack = req[owner] (combinational, only in XFER).
  - Write (owner_dir=1): uio_oe=all-ones, uio_out=wdata slice of owner. Both combinational from state/owner.
  - Read (owner_dir=0): uio_oe=0, uio_out=0. On ack, rdata<=uio_in and rvalid=1 the following cycle.
  - Each ack increments the beat counter.
  - Exit to IDLE (gnt<=0) at the clock edge after a cycle where any of these holds:
    - ack & last[owner]
    - req[owner]=0 (no ack that cycle)
    - ack and beat count reaches HOLD_MAX
  - Beat counter clears on exit.
- Minimum gap between two grants is TURN_CYC+1 cycles: one IDLE cycle plus TURN.
  - uio_oe is 0 in IDLE and TURN.
- Grant latency: req sampled in IDLE at cycle t gives gnt at cycle t+1+TURN_CYC.
- Changes to dir during a grant are ignored.
- Requests from non-owners are ignored until IDLE.
- ena=0 in any state goes to IDLE next edge: gnt=0, uio_oe=0. No ack is issued in a cycle where ena=0.
- Simultaneous last and HOLD_MAX reached: single exit, no extra effect.
- A requester that held the bus gets lowest priority next arbitration, even if it was preempted at HOLD_MAX.
- uio_oe never transitions directly from write-owner A to write-owner B without ≥1 all-zero cycle.

Test Plan:
- Reset, then req=3'b001, dir=1, wdata0=8'hA5, last on beat 2 -> gnt=001 at cycle 2. uio_oe=FF and uio_out=A5 for 2 cycles, ack=1 both. Then uio_oe=00, busy=0.
- req=3'b111 all held with last=0, HOLD_MAX=4 -> grants rotate 001,010,100,001. Each grant gets exactly 4 ack cycles. ≥2 cycles with uio_oe=00 between grants.
- Read: req1 only, dir=0, uio_in=8'h3C then 8'hC3 -> rdata=3C then C3, each one cycle after its ack with rvalid=1. uio_oe=00 throughout.
- Deassert ena mid-XFER on beat 2 of a write -> next cycle gnt=0, uio_oe=00, ack=0. Reasserting ena with req held re-arbitrates via TURN.
- rst=1 mid write burst -> next cycle all outputs 0. First grant after reset goes to req0 even if req2 is also set.
- req0 drops during TURN -> no gnt, no ack, state back to IDLE. Pending req2 granted TURN_CYC+1 cycles later.
